mel_mac: RTL and testbench

Parametrised, fully pipelined unsigned multiply-accumulate for the mel filter stage. It takes one (power-spectrum bin, filter coefficient) pair per cycle and accumulates products over a band delimited by `first`/`last` flags. At band end it emits one scaled, optionally rounded, saturated mel coefficient. A band counter tags each result and flags frame completion. It replaces the single-product multiplier in the mel filter datapath.

---
 rtl/mel_mac.sv | 195 +++++++++++++++++++
 tb/tb_mel_mac.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mel_mac.sv
// mel_mac: fully pipelined unsigned multiply-accumulate for the mel filter stage.
//
// Takes one (spectrum bin, filter coefficient) pair per cycle. Products are
// summed over a band delimited by first/last. At band end one scaled,
// optionally rounded and saturated mel coefficient is emitted, tagged with
// a band index that wraps once per frame.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - a/b/first/last valid this cycle
//   a          - spectrum bin magnitude (unsigned, A_WIDTH)
//   b          - filter coefficient (unsigned, B_WIDTH)
//   first      - first pair of a band (qualified by in_valid)
//   last       - last pair of a band (qualified by in_valid)
//   p          - mel band result (P_WIDTH)
//   p_valid    - one-cycle pulse, p/p_sat/band_idx valid
//   p_sat      - result clipped, or accumulator saturated during the band
//   band_idx   - index of the band in p
//   frame_done - pulses with p_valid for band NUM_BANDS-1
module mel_mac #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 40,
    parameter int P_WIDTH   = 16,
    parameter int SHIFT     = 16,
    parameter int ROUND     = 1,
    parameter int NUM_BANDS = 26,
    localparam int IDX_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic                 first,
    input  logic                 last,
    output logic [P_WIDTH-1:0]   p,
    output logic                 p_valid,
    output logic                 p_sat,
    output logic [IDX_W-1:0]     band_idx,
    output logic                 frame_done
);

    localparam int PROD_W = A_WIDTH + B_WIDTH;
    localparam logic [ACC_WIDTH:0] ONE  = {{ACC_WIDTH{1'b0}}, 1'b1};
    // Guarded so SHIFT=0 never produces a negative shift amount.
    localparam int                 RSH  = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_WIDTH:0] RND  = (ROUND != 0 && SHIFT > 0) ? (ONE << RSH) : '0;
    // If P_WIDTH covers the whole scaled range the shift yields 0 and the
    // subtraction wraps to all ones, so clipping can never trigger.
    localparam logic [ACC_WIDTH:0] PMAX = (ONE << P_WIDTH) - ONE;
    localparam logic [IDX_W-1:0]   LAST_BAND = IDX_W'(NUM_BANDS - 1);

    // Round (half up) and shift, one bit wider than the accumulator so the
    // rounding addend cannot wrap.
    function automatic logic [ACC_WIDTH:0] scale_acc(input logic [ACC_WIDTH-1:0] acc);
        return ({1'b0, acc} + RND) >> SHIFT;
    endfunction

    // Returns {clipped, value}.
    function automatic logic [P_WIDTH:0] clip_res(input logic [ACC_WIDTH:0] r);
        if (r > PMAX) begin
            return {1'b1, {P_WIDTH{1'b1}}};
        end
        return {1'b0, P_WIDTH'(r)};
    endfunction

    // ---------------- S1: input register ----------------
    logic                vld_p1_q;
    logic [A_WIDTH-1:0]  a_p1_q;
    logic [B_WIDTH-1:0]  b_p1_q;
    logic                first_p1_q;
    logic                last_p1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        a_p1_q     <= a;
        b_p1_q     <= b;
        first_p1_q <= first;
        last_p1_q  <= last;
    end

    // ---------------- S2: product ----------------
    logic [PROD_W-1:0]    prod_d;
    logic                 vld_p2_q;
    logic [ACC_WIDTH-1:0] prod_p2_q;
    logic                 first_p2_q;
    logic                 last_p2_q;

    assign prod_d = {{B_WIDTH{1'b0}}, a_p1_q} * {{A_WIDTH{1'b0}}, b_p1_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
        end
    end

    always_ff @(posedge clk) begin
        prod_p2_q  <= ACC_WIDTH'(prod_d);
        first_p2_q <= first_p1_q;
        last_p2_q  <= last_p1_q;
    end

    // ---------------- S3: accumulate ----------------
    logic [ACC_WIDTH:0]   sum_d;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 ovf_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic                 ovf_q;
    logic                 vld_p3_q;

    assign sum_d = {1'b0, acc_q} + {1'b0, prod_p2_q};

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (vld_p2_q) begin
            if (first_p2_q) begin
                // Also discards any open partial band.
                acc_d = prod_p2_q;
                ovf_d = 1'b0;
            end else if (sum_d[ACC_WIDTH]) begin
                acc_d = '1;
                ovf_d = 1'b1;
            end else begin
                acc_d = sum_d[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            vld_p3_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            // Only band-closing pairs travel on to the output stage.
            vld_p3_q <= vld_p2_q & last_p2_q;
        end
    end

    // ---------------- S4: scale, saturate, output ----------------
    logic [ACC_WIDTH:0]  r_d;
    logic [P_WIDTH:0]    clip_d;
    logic [P_WIDTH-1:0]  p_q;
    logic                p_sat_q;
    logic                p_valid_q;
    logic                frame_done_q;
    logic [IDX_W-1:0]    band_idx_q;
    logic [IDX_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    cnt_d;

    assign r_d    = scale_acc(acc_q);
    assign clip_d = clip_res(r_d);
    assign cnt_d  = (cnt_q == LAST_BAND) ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q          <= '0;
            p_sat_q      <= 1'b0;
            p_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            band_idx_q   <= '0;
            cnt_q        <= '0;
        end else begin
            p_valid_q    <= vld_p3_q;
            frame_done_q <= vld_p3_q && (cnt_q == LAST_BAND);
            if (vld_p3_q) begin
                p_q        <= clip_d[P_WIDTH-1:0];
                p_sat_q    <= clip_d[P_WIDTH] | ovf_q;
                band_idx_q <= cnt_q;
                cnt_q      <= cnt_d;
            end
        end
    end

    assign p          = p_q;
    assign p_sat      = p_sat_q;
    assign p_valid    = p_valid_q;
    assign frame_done = frame_done_q;
    assign band_idx   = band_idx_q;

endmodule

// File: tb/tb_mel_mac.sv
// Scoreboard bench for mel_mac. Three instances share one stimulus stream:
//   u0: defaults (ROUND=1, NUM_BANDS=26)
//   u1: ROUND=0
//   u2: NUM_BANDS=4
module tb_mel_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        first;
    logic        last;

    logic [15:0] p0, p1, p2;
    logic        pv0, pv1, pv2;
    logic        ps0, ps1, ps2;
    logic [4:0]  bi0, bi1;
    logic [1:0]  bi2;
    logic        fd0, fd1, fd2;

    always #5 clk = ~clk;

    mel_mac u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .first(first), .last(last),
        .p(p0), .p_valid(pv0), .p_sat(ps0), .band_idx(bi0), .frame_done(fd0)
    );
    mel_mac #(.ROUND(0)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .first(first), .last(last),
        .p(p1), .p_valid(pv1), .p_sat(ps1), .band_idx(bi1), .frame_done(fd1)
    );
    mel_mac #(.NUM_BANDS(4)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .first(first), .last(last),
        .p(p2), .p_valid(pv2), .p_sat(ps2), .band_idx(bi2), .frame_done(fd2)
    );

    typedef struct {
        logic [15:0] p;
        logic        sat;
        logic [4:0]  idx;
        logic        fd;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int cnt[3];
    int nbands[3] = '{26, 26, 4};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic make_exp(input int i, input logic [15:0] pe, input logic s, output exp_t e);
        e.p   = pe;
        e.sat = s;
        e.idx = 5'(cnt[i]);
        e.fd  = (cnt[i] == nbands[i] - 1);
        e.due = cyc + 4;
        cnt[i] = (cnt[i] + 1) % nbands[i];
    endtask

    // pr: expected with rounding, pt: expected with truncation.
    task automatic expect_band(input logic [15:0] pr, input logic [15:0] pt, input logic s);
        exp_t e;
        make_exp(0, pr, s, e); q0.push_back(e);
        make_exp(1, pt, s, e); q1.push_back(e);
        make_exp(2, pr, s, e); q2.push_back(e);
    endtask

    task automatic pair(input logic [15:0] av, input logic [15:0] bv, input logic f, input logic l,
                        input logic [15:0] pr, input logic [15:0] pt, input logic s);
        @(negedge clk);
        in_valid = 1'b1;
        a = av; b = bv; first = f; last = l;
        if (l) expect_band(pr, pt, s);
    endtask

    // Idle cycle with junk flags that must be ignored.
    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        first = 1'b1; last = 1'b1;
        a = 16'($urandom); b = 16'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 20) begin
            idle();
            n++;
        end
        chk("drain_timeout", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_p"},   {p0, p1, p2}, 32'd0);
        chk({tag, "_pv"},  {pv0, pv1, pv2}, 32'd0);
        chk({tag, "_sat"}, {ps0, ps1, ps2}, 32'd0);
        chk({tag, "_idx"}, {bi0, bi1, bi2}, 32'd0);
        chk({tag, "_fd"},  {fd0, fd1, fd2}, 32'd0);
    endtask

    // Reset for one edge; optionally present a valid closing pair at the same time.
    task automatic pulse_rst(input logic with_valid);
        @(negedge clk);
        rst = 1'b1;
        in_valid = with_valid;
        a = 16'h1000; b = 16'h0100; first = 1'b0; last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        first = 1'b0; last = 1'b0;
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        check_zero("after_rst");
    endtask

    task automatic mon(input int i, input logic [15:0] pp, input logic ss, input logic [4:0] ii,
                       input logic ff);
        exp_t e;
        string tag;
        tag = $sformatf("u%0d", i);
        if (i == 0 && q0.size() == 0 || i == 1 && q1.size() == 0 || i == 2 && q2.size() == 0) begin
            chk({tag, "_unexpected_pvalid"}, 32'd1, 32'd0);
            return;
        end
        if (i == 0) e = q0.pop_front();
        else if (i == 1) e = q1.pop_front();
        else e = q2.pop_front();
        chk({tag, "_p"},       32'(pp), 32'(e.p));
        chk({tag, "_sat"},     32'(ss), 32'(e.sat));
        chk({tag, "_idx"},     32'(ii), 32'(e.idx));
        chk({tag, "_fd"},      32'(ff), 32'(e.fd));
        chk({tag, "_latency"}, 32'(cyc), 32'(e.due));
    endtask

    always @(negedge clk) begin
        if (pv0) mon(0, p0, ps0, bi0, fd0);
        if (pv1) mon(1, p1, ps1, bi1, fd1);
        if (pv2) mon(2, p2, ps2, {3'b000, bi2}, fd2);
        if (!pv0 && fd0 || !pv1 && fd1 || !pv2 && fd2)
            chk("frame_done_without_pvalid", 32'd1, 32'd0);
    end

    initial begin
        for (int i = 0; i < 3; i++) cnt[i] = 0;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; first = 1'b0; last = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_zero("reset");
        idle();

        // Single multiply: 0x8000*0x8000 = 0x40000000 -> 0x4000.
        pair(16'h8000, 16'h8000, 1, 1, 16'h4000, 16'h4000, 0);
        drain();

        // Partial band opened then abandoned by a new first.
        pair(16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 0);
        idle();
        // Three-term band: 3 * 0x100000 = 0x300000 -> 0x30.
        pair(16'h1000, 16'h0100, 1, 0, 0, 0, 0);
        pair(16'h1000, 16'h0100, 0, 0, 0, 0, 0);
        pair(16'h1000, 16'h0100, 0, 1, 16'h0030, 16'h0030, 0);
        drain();

        // Rounding: 0x8000 -> 1 rounded, 0 truncated.
        pair(16'h0080, 16'h0100, 1, 1, 16'h0001, 16'h0000, 0);
        drain();

        // Saturation: 2*0xFFFE0001 >> 16 = 0x1FFFC clips; then a clean band.
        pair(16'hFFFF, 16'hFFFF, 1, 0, 0, 0, 0);
        pair(16'hFFFF, 16'hFFFF, 0, 1, 16'hFFFF, 16'hFFFF, 1);
        pair(16'h0001, 16'h0001, 1, 1, 16'h0000, 16'h0000, 0);
        drain();

        // Band counter from a clean start: five back-to-back single-term bands.
        pulse_rst(1'b0);
        idle();
        for (int k = 0; k < 5; k++)
            pair(16'(16'h0100 * (k + 1)), 16'h0100, 1, 1, 16'(k + 1), 16'(k + 1), 0);
        drain();

        // Reset mid-band, with a valid closing pair presented alongside reset.
        pair(16'h1000, 16'h0100, 1, 0, 0, 0, 0);
        pair(16'h1000, 16'h0100, 0, 0, 0, 0, 0);
        pulse_rst(1'b1);
        idle();
        idle();
        // Fresh band: 2*0x8000 = 0x10000 -> 1, band 0.
        pair(16'h0002, 16'h8000, 1, 1, 16'h0001, 16'h0001, 0);
        drain();
        repeat (4) idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
